// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between the operand sequencer, alu_pipe and the result sink.
// master = sequencer/sink side, slave = alu_pipe.
interface alu_pipe_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, op, a, b, tag_in, out_ready,
        input  in_ready, out_valid, result, carry, zero, negative, overflow, tag_out
    );

    modport slave (
        input  in_valid, op, a, b, tag_in, out_ready,
        output in_ready, out_valid, result, carry, zero, negative, overflow, tag_out
    );
endinterface

// File: rtl/alu_pipe.sv
// Purpose: two-stage pipelined ALU (add/sub/and/or/xor/not/shr/shl) with C/Z/N/V flags and tag pass-through.
// Latency: beat accepted at edge N is presented on the output after edge N+1.
// Backpressure: valid/ready; in_ready = !s1_valid || s2_free, full throughput while out_ready is high.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_pipe_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } beat_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             zero;
        logic             negative;
        logic             overflow;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic       s1_valid;
    beat_t      s1_beat;
    logic       s2_valid;
    res_t       s2_res;
    res_t       s2_next;
    logic       s2_free;
    logic       s1_adv;
    logic       in_ready;
    logic       in_fire;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;

    assign s2_free  = !s2_valid || bus.out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign in_fire  = bus.in_valid && in_ready;

    // One extra bit on each side of the shifts captures the last bit shifted out.
    always_comb begin
        sum     = {1'b0, s1_beat.a} + {1'b0, s1_beat.b};
        diff    = {1'b0, s1_beat.a} - {1'b0, s1_beat.b};
        shr_ext = {s1_beat.a, 1'b0} >> s1_beat.b;
        shl_ext = {1'b0, s1_beat.a} << s1_beat.b;
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (s1_beat.op)
            3'b000: begin
                res_c   = sum[MSB:0];
                carry_c = sum[WIDTH];
                ovf_c   = (s1_beat.a[MSB] == s1_beat.b[MSB]) && (sum[MSB] != s1_beat.a[MSB]);
            end
            3'b001: begin
                res_c   = diff[MSB:0];
                carry_c = diff[WIDTH];
                ovf_c   = (s1_beat.a[MSB] != s1_beat.b[MSB]) && (diff[MSB] != s1_beat.a[MSB]);
            end
            3'b010: res_c = s1_beat.a & s1_beat.b;
            3'b011: res_c = s1_beat.a | s1_beat.b;
            3'b100: res_c = s1_beat.a ^ s1_beat.b;
            3'b101: res_c = ~s1_beat.a;
            3'b110: begin
                res_c   = shr_ext[WIDTH:1];
                carry_c = shr_ext[0];
            end
            default: begin
                res_c   = shl_ext[MSB:0];
                carry_c = shl_ext[WIDTH];
            end
        endcase

        s2_next          = '0;
        s2_next.result   = res_c;
        s2_next.carry    = carry_c;
        s2_next.zero     = (res_c == '0);
        s2_next.negative = res_c[MSB];
        s2_next.overflow = ovf_c;
        s2_next.tag      = s1_beat.tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_beat  <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_beat  <= {bus.op, bus.a, bus.b, bus.tag_in};
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output registers only load on advance, so they hold steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_res   <= s2_next;
        end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_res.result;
    assign bus.carry     = s2_res.carry;
    assign bus.zero      = s2_res.zero;
    assign bus.negative  = s2_res.negative;
    assign bus.overflow  = s2_res.overflow;
    assign bus.tag_out   = s2_res.tag;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: queue-driven stimulus, scoreboard against an arithmetic model of the op set.
// Covers reset, latency, stall/hold, gap-free streaming, mid-flight reset and random backpressure.
module tb_alu_pipe;
    localparam int W = 8;
    localparam int T = 4;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [T-1:0] tag;
    } beat_t;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
        logic [T-1:0] tag;
    } out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W), .TAG_W(T)) bus();
    alu_pipe #(.WIDTH(W), .TAG_W(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    beat_t tx_q[$];
    out_t  exp_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    n_xfer = 0;
    bit    rand_bp = 1'b0;
    bit    ready_fixed = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int op, input int a, input int b, input int tag);
        beat_t x;
        x.op  = 3'(op);
        x.a   = W'(a);
        x.b   = W'(b);
        x.tag = T'(tag);
        return x;
    endfunction

    // Reference: plain integer arithmetic, signed overflow as "result not representable".
    function automatic out_t model(input beat_t bt);
        int   ua;
        int   ub;
        int   sa;
        int   sb;
        int   r;
        int   c;
        int   v;
        int   smax;
        int   smin;
        out_t o;
        ua = int'(bt.a);
        ub = int'(bt.b);
        sa = int'($signed(bt.a));
        sb = int'($signed(bt.b));
        r = 0; c = 0; v = 0;
        smax = (1 << (W - 1)) - 1;
        smin = -(1 << (W - 1));
        case (bt.op)
            3'd0: begin r = ua + ub; c = (r >> W) & 1; v = ((sa + sb) > smax || (sa + sb) < smin) ? 1 : 0; end
            3'd1: begin r = ua - ub; c = (ua < ub) ? 1 : 0; v = ((sa - sb) > smax || (sa - sb) < smin) ? 1 : 0; end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = ~ua;
            3'd6: begin
                if (ub == 0) r = ua;
                else if (ub <= W) begin r = ua >> ub; c = (ua >> (ub - 1)) & 1; end
            end
            default: begin
                if (ub == 0) r = ua;
                else if (ub <= W) begin r = ua << ub; c = (ua >> (W - ub)) & 1; end
            end
        endcase
        o.res = W'(r & ((1 << W) - 1));
        o.c   = c[0];
        o.v   = v[0];
        o.z   = (o.res == '0);
        o.n   = o.res[W-1];
        o.tag = bt.tag;
        return o;
    endfunction

    // Driver: sole writer of the DUT inputs; presents tx_q[0] until accepted.
    initial begin
        bit took;
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.tag_in = '0;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            took = bus.in_valid && bus.in_ready && rst_n;
            @(posedge clk);
            #1;
            if (took) void'(tx_q.pop_front());
            bus.out_ready = rand_bp ? 1'($urandom_range(0, 1)) : ready_fixed;
            if (tx_q.size() > 0 && ((bus.in_valid && !took) || !rand_bp || $urandom_range(0, 3) != 0)) begin
                bus.in_valid = 1'b1;
                {bus.op, bus.a, bus.b, bus.tag_in} = tx_q[0];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
    end

    // Scoreboard: checks every output transfer and every stalled cycle.
    initial begin
        out_t prev;
        out_t act;
        out_t e;
        bit   held;
        held = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            act = {bus.result, bus.carry, bus.zero, bus.negative, bus.overflow, bus.tag_out};
            if (!rst_n) begin
                exp_q.delete();
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", 64'(bus.out_valid), 64'(1));
                    chk("hold_stable", 64'(act), 64'(prev));
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_xfer++;
                    chk("beat_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("beat_result", 64'(act), 64'(e));
                    end
                end
                held = bus.out_valid && !bus.out_ready;
                prev = act;
                if (bus.in_valid && bus.in_ready)
                    exp_q.push_back(model({bus.op, bus.a, bus.b, bus.tag_in}));
            end
        end
    end

    task automatic wait_tx(input int budget);
        int n;
        n = 0;
        while (tx_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("tx_drain", 64'(tx_q.size()), 64'(0));
    endtask

    task automatic wait_out(input int budget);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("out_drain", 64'(tx_q.size() + exp_q.size()), 64'(0));
    endtask

    initial begin
        int run;
        int n;
        int x0;
        int op;

        // Model pinned to hand-computed vectors: {res, c, z, n, v, tag=0}.
        chk("pin_add_ff_01", 64'(model(mk(0, 'hFF, 'h01, 0))), 64'h00C0);
        chk("pin_sub_80_01", 64'(model(mk(1, 'h80, 'h01, 0))), 64'h7F10);
        chk("pin_sub_03_05", 64'(model(mk(1, 'h03, 'h05, 0))), 64'hFEA0);
        chk("pin_shl_81_1",  64'(model(mk(7, 'h81, 1, 0))),    64'h0280);
        chk("pin_shr_81_8",  64'(model(mk(6, 'h81, 8, 0))),    64'h00C0);
        chk("pin_shr_81_9",  64'(model(mk(6, 'h81, 9, 0))),    64'h0040);
        chk("pin_not_0f",    64'(model(mk(5, 'h0F, 'h33, 0))), 64'hF020);

        #2;
        chk("rst_outputs", 64'({bus.out_valid, bus.result, bus.carry, bus.zero, bus.negative,
                                bus.overflow, bus.tag_out}), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Stalled single add: result must sit on the outputs with its flags and tag.
        ready_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        tx_q.push_back(mk(0, 'hFF, 'h01, 3));
        repeat (4) @(posedge clk);
        #2;
        chk("add_held", 64'({bus.out_valid, bus.result, bus.carry, bus.zero, bus.negative,
                             bus.overflow, bus.tag_out}), 64'(17'h100C3));
        ready_fixed = 1'b1;
        wait_out(50);

        tx_q.push_back(mk(1, 'h80, 'h01, 1));
        tx_q.push_back(mk(1, 'h03, 'h05, 2));
        tx_q.push_back(mk(7, 'h81, 1, 3));
        tx_q.push_back(mk(6, 'h81, 8, 4));
        tx_q.push_back(mk(6, 'h81, 9, 5));
        tx_q.push_back(mk(7, 'h81, 8, 6));
        tx_q.push_back(mk(6, 'h81, 0, 7));
        tx_q.push_back(mk(5, 'h0F, 'hAA, 8));
        tx_q.push_back(mk(2, 'hF0, 'h3C, 9));
        tx_q.push_back(mk(3, 'hF0, 'h0F, 10));
        tx_q.push_back(mk(4, 'hFF, 'hFF, 11));
        tx_q.push_back(mk(0, 'h7F, 'h01, 12));
        wait_out(100);

        // Backpressure: only two beats fit while the sink is stalled.
        ready_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) tx_q.push_back(mk(0, int'($urandom), int'($urandom), i));
        repeat (8) @(posedge clk);
        #2;
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
        chk("bp_two_accepted", 64'(tx_q.size()), 64'(2));
        chk("bp_head_tag0", 64'({bus.out_valid, bus.tag_out}), 64'({1'b1, 4'h0}));
        ready_fixed = 1'b1;
        @(posedge clk);
        #2;
        run = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) run++;
        end
        chk("bp_no_gap", 64'(run), 64'(4));
        wait_out(50);

        // Streaming: 16 beats over all ops, output valid for 16 straight cycles.
        for (int i = 0; i < 16; i++) begin
            op = i % 8;
            tx_q.push_back(mk(op, int'($urandom), (op >= 6) ? int'($urandom_range(0, W + 2)) : int'($urandom), i));
        end
        n = 0;
        @(negedge clk);
        while (!(bus.in_valid && bus.in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stream_started", 64'(n < 20), 64'(1));
        @(negedge clk);
        chk("stream_latency_gap", 64'(bus.out_valid), 64'(0));
        run = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.out_valid) run++;
        end
        chk("stream_run", 64'(run), 64'(16));
        @(negedge clk);
        chk("stream_end", 64'(bus.out_valid), 64'(0));
        wait_out(50);

        // Reset with two beats in flight.
        ready_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        tx_q.push_back(mk(0, 'h12, 'h34, 5));
        tx_q.push_back(mk(4, 'h55, 'hAA, 6));
        wait_tx(20);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 64'({bus.out_valid, bus.result, bus.carry, bus.zero, bus.negative,
                                    bus.overflow, bus.tag_out}), 64'(0));
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'(1));
        ready_fixed = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        x0 = n_xfer;
        tx_q.push_back(mk(1, 'h03, 'h05, 9));
        wait_out(50);
        chk("post_rst_single_beat", 64'(n_xfer - x0), 64'(1));

        // Random ops, random sink stalls and source gaps.
        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 7));
            tx_q.push_back(mk(op, int'($urandom),
                              (op >= 6 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, W + 2)) : int'($urandom),
                              int'($urandom)));
        end
        wait_tx(3000);
        rand_bp = 1'b0;
        ready_fixed = 1'b1;
        wait_out(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit registered ALU.
- Has a configurable data width and a valid/ready handshake on input and output, so it sustains one operation per cycle under backpressure.
- Produces a full flag set (carry, zero, negative, overflow) and carries a pass-through tag.
- Sits between an operand sequencer and a result sink in the datapath.

Parameters:
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- TAG_W, 4: width of the pass-through transaction tag; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept an operand beat
- op  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a, 110 shr, 111 shl
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (unsigned shift amount for 110/111)
- tag_in  input  TAG_W  tag, returned unchanged with the result
- out_valid  output  1  result beat valid
- out_ready  input  1  sink accepts the result beat
- result  output  WIDTH  operation result
- carry  output  1  carry/borrow/shifted-out bit
- zero  output  1  result == 0
- negative  output  1  result[WIDTH-1]
- overflow  output  1  signed overflow (add/sub only)
- tag_out  output  TAG_W  tag of the current result

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid=0; result, carry, zero, negative, overflow, tag_out all 0.
  - Internal stage-1 valid=0; in_ready=1 as soon as rst_n is high.
  - Reset mid-operation discards all in-flight beats; nothing is replayed.
- Pipeline: 2 register stages.
  - S1 captures op, a, b and tag on in_valid && in_ready.
  - S2 captures the computed result and flags when S1 advances.
  - Latency: beat accepted at edge N gives out_valid=1 after edge N+1 when not stalled.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free (combinational from out_ready; no combinational path from in_valid).
  - Output transfer occurs on out_valid && out_ready.
  - Outputs stay stable while out_valid && !out_ready.
  - out_valid drops only after a transfer with no new beat arriving.
  - Full throughput: one beat per cycle while out_ready=1.
  - Simultaneous output transfer and S1 advance in the same cycle is legal and loses nothing.
- Arithmetic: all computed in WIDTH+1 bits, result truncated to WIDTH.
  - add: result=a+b; carry=bit WIDTH of the sum; overflow=(a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
  - sub: result=a-b; carry=borrow=(a<b unsigned); overflow=(a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
  - and/or/xor: bitwise; carry=0; overflow=0.
  - not: result=~a; b ignored; carry=0; overflow=0.
  - shr (logical): result=a>>b.
    - carry=a[b-1] for 1<=b<=WIDTH; carry=0 for b=0.
    - b>WIDTH: result=0, carry=0.
  - shl: result=a<<b.
    - carry=a[WIDTH-b] for 1<=b<=WIDTH; carry=0 for b=0.
    - b>WIDTH: result=0, carry=0.
  - zero and negative are derived from the final result for every op.
- Beats are never reordered, dropped or duplicated; tag_out always matches tag_in of the same beat.

Test Plan:
- WIDTH=8, add a=0xFF b=0x01 tag=3, out_ready=1 -> two cycles later: result=0x00, carry=1, zero=1, negative=0, overflow=0, tag_out=3.
- sub a=0x80 b=0x01 -> result=0x7F, carry=0, overflow=1, negative=0; sub a=0x03 b=0x05 -> result=0xFE, carry=1, negative=1, overflow=0.
- shl a=0x81 b=1 -> result=0x02, carry=1; shr a=0x81 b=8 -> result=0x00, carry=1, zero=1; shr a=0x81 b=9 -> result=0x00, carry=0.
- Backpressure: out_ready=0, drive 4 back-to-back beats with tags 0..3 -> only tags 0,1 accepted, in_ready=0 thereafter, and result held stable with tag 0. Release out_ready -> tags 0,1,2,3 emerge in order with no gaps once streaming, and no loss.
- Streaming: 16 random beats (all 8 ops), in_valid=1, out_ready=1 continuously -> out_valid held high for 16 consecutive cycles starting 2 cycles after the first beat is accepted, and every result/flag matches the reference model.
- Reset mid-operation: 2 beats in flight, assert rst_n=0 asynchronously between edges -> out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and the next beat produces a correct result with no residue of earlier beats.
